// File: rtl/hamming74_decode_arbiter.sv
// Hamming(7,4) decode shared among NUM_REQ requesters through a round-robin
// arbiter. The decoded word lands in a one-entry output register that carries
// the requester id and a corrected flag. A saturating counter tallies
// codewords whose syndrome was nonzero.

// Per-lane combinational Hamming(7,4) syndrome decode and single-bit correction.
module hamming74_lane_dec (
  input  logic [6:0] cw_i,
  output logic [3:0] data_o,
  output logic       corr_o
);
  logic [2:0] syn;
  logic [3:0] flip;

  // Syndrome, then map it to the data bit to flip. Syndromes that point at a
  // parity bit leave the data bits untouched.
  always_comb begin
    syn[2] = cw_i[6] ^ cw_i[5] ^ cw_i[4] ^ cw_i[2];
    syn[1] = cw_i[6] ^ cw_i[5] ^ cw_i[3] ^ cw_i[1];
    syn[0] = cw_i[6] ^ cw_i[4] ^ cw_i[3] ^ cw_i[0];
    flip   = 4'b0000;
    case (syn)
      3'b111:  flip = 4'b1000;
      3'b110:  flip = 4'b0100;
      3'b101:  flip = 4'b0010;
      3'b011:  flip = 4'b0001;
      default: flip = 4'b0000;
    endcase
    data_o = cw_i[6:3] ^ flip;
    corr_o = |syn;
  end
endmodule

module hamming74_decode_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [7*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [3:0]           out_data_o,
  output logic [IDW-1:0]       out_id_o,
  output logic                 out_corrected_o,
  input  logic                 clr_count_i,
  output logic [CNT_W-1:0]     corr_count_o
);

  typedef struct packed {
    logic [3:0]     data;
    logic [IDW-1:0] id;
    logic           corr;
  } rsp_t;

  logic [NUM_REQ-1:0][3:0] dec_data;
  logic [NUM_REQ-1:0]      dec_corr;

  // One decoder per lane; the arbiter only has to pick a finished result.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    hamming74_lane_dec u_dec (
      .cw_i   (req_data_i[7*i +: 7]),
      .data_o (dec_data[i]),
      .corr_o (dec_corr[i])
    );
  end

  logic               out_valid_q, out_valid_d;
  rsp_t               rsp_q, rsp_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic               gnt_vld;
  logic [IDW-1:0]     gnt_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               gnt;
  int                 j;

  // Round-robin search from the pointer upward with wrap; first valid wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_q) + k) % NUM_REQ;
      if (!gnt_vld && req_valid_i[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(j);
      end
    end
  end

  // Grant only when the output register is empty or draining this cycle.
  always_comb begin
    accept = ~out_valid_q | out_ready_i;
    gnt    = accept & gnt_vld;
    gnt_oh = '0;
    if (gnt) gnt_oh[gnt_idx] = 1'b1;
  end

  assign req_ready_o = gnt_oh;

  // Next state for output register, pointer and corrected-word counter.
  always_comb begin
    out_valid_d = out_valid_q;
    rsp_d       = rsp_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    if (gnt) begin
      out_valid_d = 1'b1;
      rsp_d.data  = dec_data[gnt_idx];
      rsp_d.id    = gnt_idx;
      rsp_d.corr  = dec_corr[gnt_idx];
      ptr_d       = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
    if (clr_count_i)
      cnt_d = '0;
    else if (gnt && dec_corr[gnt_idx] && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers; async reset drops any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      rsp_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rsp_q       <= rsp_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid_o     = out_valid_q;
  assign out_data_o      = rsp_q.data;
  assign out_id_o        = rsp_q.id;
  assign out_corrected_o = rsp_q.corr;
  assign corr_count_o    = cnt_q;

endmodule

// File: tb/tb_hamming74_decode_arbiter.sv
// Directed bench for hamming74_decode_arbiter: stimulus pushes expected
// output words into a queue, a negedge monitor pops and compares on every
// output transfer. A second instance with a 2-bit counter covers saturation.
module tb_hamming74_decode_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [27:0] req_data  = '0;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_data;
  logic [1:0]  out_id;
  logic        out_corr;
  logic        clr = 1'b0;
  logic [15:0] cnt;

  logic [3:0]  s_valid = '0;
  logic [27:0] s_data  = '0;
  logic [3:0]  s_ready;
  logic        s_ovalid;
  logic        s_oready = 1'b0;
  logic [3:0]  s_odata;
  logic [1:0]  s_oid;
  logic        s_ocorr;
  logic        s_clr = 1'b0;
  logic [1:0]  s_cnt;

  int vecs = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] id;
    logic       corr;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  hamming74_decode_arbiter #(.NUM_REQ(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_id_o(out_id), .out_corrected_o(out_corr),
    .clr_count_i(clr), .corr_count_o(cnt)
  );

  hamming74_decode_arbiter #(.NUM_REQ(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .req_valid_i(s_valid), .req_data_i(s_data),
    .req_ready_o(s_ready), .out_valid_o(s_ovalid), .out_ready_i(s_oready),
    .out_data_o(s_odata), .out_id_o(s_oid), .out_corrected_o(s_ocorr),
    .clr_count_i(s_clr), .corr_count_o(s_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [3:0] d, input logic [1:0] id, input logic c);
    exp_t e;
    e.data = d; e.id = id; e.corr = c;
    sb.push_back(e);
  endtask

  // Monitor: every output transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      vecs++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got data=%0h id=%0d corr=%0b with empty queue",
                 out_data, out_id, out_corr);
      end else begin
        e = sb.pop_front();
        if ({out_data, out_id, out_corr} !== e) begin
          fails++;
          $display("FAIL out_word: got data=%0h id=%0d corr=%0b expected data=%0h id=%0d corr=%0b",
                   out_data, out_id, out_corr, e.data, e.id, e.corr);
        end
      end
    end
  end

  initial begin
    int exp5[5] = '{1, 2, 3, 3, 3};
    // reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_id", 32'(out_id), 0);
    chk("rst_out_corr", 32'(out_corr), 0);
    chk("rst_count", 32'(cnt), 0);
    step(); step();
    rst = 1'b0;
    step();

    // 1) clean codeword from req0
    out_ready = 1'b1;
    req_data[6:0] = 7'h59;
    req_valid = 4'b0001;
    #1 chk("t1_ready", 32'(req_ready), 32'b0001);
    push(4'hB, 2'd0, 1'b0);
    step();
    req_valid = '0;
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_count", 32'(cnt), 0);
    step();
    chk("t1_drained", 32'(out_valid), 0);

    // 2) req2: c6 flipped, then c0 flipped
    req_data[20:14] = 7'h19;
    req_valid = 4'b0100;
    push(4'hB, 2'd2, 1'b1);
    step();
    chk("t2a_count", 32'(cnt), 1);
    req_data[20:14] = 7'h58;
    push(4'hB, 2'd2, 1'b1);
    step();
    req_valid = '0;
    chk("t2b_count", 32'(cnt), 2);
    step();

    // fresh pointer for the round-robin sequence
    rst = 1'b1; #1; rst = 1'b0;
    step();

    // 3) all requesters valid, full throughput
    req_data = {7'h7F, 7'h2D, 7'h00, 7'h59};
    push(4'hB, 2'd0, 1'b0);
    push(4'h0, 2'd1, 1'b0);
    push(4'h5, 2'd2, 1'b0);
    push(4'hF, 2'd3, 1'b0);
    push(4'hB, 2'd0, 1'b0);
    req_valid = 4'b1111;
    #1 chk("t3_first_ready", 32'(req_ready), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t3_valid%0d", i), 32'(out_valid), 1);
    end

    // 4) stall with a pending word, then release
    out_ready = 1'b0;
    #1 chk("t4_ready_stalled", 32'(req_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t4_hold_valid%0d", i), 32'(out_valid), 1);
      chk($sformatf("t4_hold_data%0d", i), 32'(out_data), 32'hB);
      chk($sformatf("t4_hold_id%0d", i), 32'(out_id), 0);
      chk($sformatf("t4_hold_ready%0d", i), 32'(req_ready), 0);
    end
    out_ready = 1'b1;
    push(4'h0, 2'd1, 1'b0);
    #1 chk("t4_release_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    step();
    chk("t4_drained", 32'(out_valid), 0);

    // 5) 2-bit counter saturation and clear priority
    s_oready = 1'b1;
    s_data[6:0] = 7'h19;
    s_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t5_cnt%0d", i), 32'(s_cnt), 32'(exp5[i]));
    end
    s_clr = 1'b1;
    step();
    chk("t5_clr", 32'(s_cnt), 0);
    s_clr = 1'b0;
    s_valid = '0;
    step();

    // 6) async reset with a word in flight
    req_data[6:0] = 7'h59;
    req_valid = 4'b0001;
    step();
    chk("t6_pre_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_data", 32'(out_data), 0);
    chk("t6_rst_id", 32'(out_id), 0);
    chk("t6_rst_corr", 32'(out_corr), 0);
    chk("t6_rst_count", 32'(cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b1111;
    #1 chk("t6_first_ready", 32'(req_ready), 32'b0001);
    push(4'hB, 2'd0, 1'b0);
    @(posedge clk); #1;
    req_valid = '0;
    step();
    step();

    chk("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
